exp_pipe: RTL

//  Pipelined, parametrised e^x unit for the Black-Scholes datapath; successor to the combinational exp LUT.

---
 rtl/exp_pkg.sv | 48 ++++
 rtl/exp_lut_rom.sv | 41 ++++
 rtl/exp_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// exp_pkg: shared defaults, types and LUT helpers for the pipelined e^x unit.
// Holds the default Q6.10 format, fixed_t/clamp_t types and elaboration-time
// functions for LUT depth, address width and entry values.
package exp_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int FRAC_DEF      = 10;
  localparam int X_RANGE_DEF   = 10;
  localparam int STEP_LOG2_DEF = 5;
  localparam int TAG_W_DEF     = 4;
  localparam int ONE_FX        = 1 << FRAC_DEF;

  typedef logic signed [WIDTH_DEF-1:0] fixed_t;

  // hi: input was positive and clamped to 0; lo: input was below -X_RANGE
  typedef struct packed {
    logic hi;
    logic lo;
  } clamp_t;

  function automatic int lut_depth(int x_range, int frac, int step_log2);
    return ((x_range << frac) >> step_log2) + 1;
  endfunction

  function automatic int lut_addr_w(int depth);
    return $clog2(depth);
  endfunction

  // Entry i holds round(e^(-x_range + i*step) * 2^frac), saturated to the
  // positive range. Only ever called with constant arguments, so it is folded
  // at elaboration into ROM contents.
  function automatic int lut_entry(int i, int width, int frac, int x_range, int step_log2);
    real xr;
    real yr;
    int  v;
    int  vmax;
    vmax = (1 << (width - 1)) - 1;
    if (i == lut_depth(x_range, frac, step_log2) - 1) begin
      v = 1 << frac;
    end else begin
      xr = -real'(x_range) + real'(i) * real'(1 << step_log2) / real'(1 << frac);
      yr = $exp(xr) * real'(1 << frac) + 0.5;
      v  = $rtoi(yr);
    end
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/exp_lut_rom.sv
// exp_lut_rom: DEPTH x WIDTH constant e^x table with synchronous read ports.
// Latency 1 cycle (registered read); en=0 holds both outputs (pipeline stall).
// Ports: clk; en; addr_a/data_a always present; addr_b/data_b only when
// EXP_PIPE_INTERP_EN is defined (second port feeds interpolation).
module exp_lut_rom
  import exp_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int X_RANGE   = X_RANGE_DEF,
  parameter int STEP_LOG2 = STEP_LOG2_DEF,
  parameter int DEPTH     = lut_depth(X_RANGE, FRAC, STEP_LOG2),
  parameter int ADDR_W    = lut_addr_w(DEPTH)
)(
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr_a,
  output logic [WIDTH-1:0]  data_a
`ifdef EXP_PIPE_INTERP_EN
  ,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [WIDTH-1:0]  data_b
`endif
);

  logic [WIDTH-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_lut
    assign rom[g] = WIDTH'(lut_entry(g, WIDTH, FRAC, X_RANGE, STEP_LOG2));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= rom[addr_a];
`ifdef EXP_PIPE_INTERP_EN
      data_b <= rom[addr_b];
`endif
    end
  end

endmodule

// File: rtl/exp_pipe.sv
// exp_pipe: pipelined e^x for x in [-X_RANGE, 0], LUT plus optional linear interpolation.
// Latency 3 cycles accept->out_valid, 1 result/cycle, tag passthrough, order preserved.
// Backpressure: global stall when out_valid & !out_ready; in_ready = !stall.
// Ports: clk, rst (async high); in_valid/in_ready/x_in/in_tag; out_valid/out_ready/
// exp_out/out_tag/out_clamp {hi,lo}. Macro EXP_PIPE_INTERP_EN enables interpolation
// (otherwise exp_out is the floor-index LUT entry).
module exp_pipe
  import exp_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int X_RANGE   = X_RANGE_DEF,
  parameter int STEP_LOG2 = STEP_LOG2_DEF,
  parameter int TAG_W     = TAG_W_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] exp_out,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_clamp
);

  localparam int SPAN   = X_RANGE << FRAC;
  localparam int DEPTH  = lut_depth(X_RANGE, FRAC, STEP_LOG2);
  localparam int ADDR_W = lut_addr_w(DEPTH);
  localparam logic signed [WIDTH:0] SPAN_S = (WIDTH + 1)'(SPAN);

  logic stall;
  logic adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  // S1: clamp to [-SPAN, 0] and shift to an unsigned offset in [0, SPAN]
  logic signed [WIDTH:0] x_ext;
  logic signed [WIDTH:0] x_c;
  logic [WIDTH:0]        off;
  clamp_t                clamp_c;

  always_comb begin
    x_ext   = {x_in[WIDTH-1], x_in};
    x_c     = x_ext;
    clamp_c = '0;
    if (x_ext < -SPAN_S) begin
      x_c        = -SPAN_S;
      clamp_c.lo = 1'b1;
    end else if (!x_ext[WIDTH] && (x_ext != '0)) begin
      x_c        = '0;
      clamp_c.hi = 1'b1;
    end
    off = x_c + SPAN_S;
  end

  logic                 v1, v2;
  logic [ADDR_W-1:0]    idx1;
  logic [STEP_LOG2-1:0] frac1, frac2;
  clamp_t               clamp1, clamp2;
  logic [TAG_W-1:0]     tag1, tag2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      idx1   <= '0;
      frac1  <= '0;
      clamp1 <= '0;
      tag1   <= '0;
      v2     <= 1'b0;
      frac2  <= '0;
      clamp2 <= '0;
      tag2   <= '0;
    end else if (adv) begin
      v1     <= in_valid;
      idx1   <= off[ADDR_W+STEP_LOG2-1:STEP_LOG2];
      frac1  <= off[STEP_LOG2-1:0];
      clamp1 <= clamp_c;
      tag1   <= in_tag;
      v2     <= v1;
      frac2  <= frac1;
      clamp2 <= clamp1;
      tag2   <= tag1;
    end
  end

  // S2: registered LUT read
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] res;
  logic             unused_bits;

`ifdef EXP_PIPE_INTERP_EN
  localparam int PW = WIDTH + STEP_LOG2 + 1;

  logic [ADDR_W-1:0] idx1_nx;
  logic [WIDTH-1:0]  y1;
  // top entry has no right neighbour; reusing it gives diff 0 there
  assign idx1_nx = (idx1 == ADDR_W'(DEPTH - 1)) ? idx1 : idx1 + 1'b1;

  exp_lut_rom #(
    .WIDTH(WIDTH), .FRAC(FRAC), .X_RANGE(X_RANGE), .STEP_LOG2(STEP_LOG2),
    .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_rom (
    .clk(clk), .en(adv),
    .addr_a(idx1), .data_a(y0),
    .addr_b(idx1_nx), .data_b(y1)
  );

  // S3: y0 + round_half_up((y1-y0)*frac / 2^STEP_LOG2)
  logic signed [WIDTH:0] diff;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  rnd;
  logic [WIDTH:0]        sum;

  always_comb begin
    diff = $signed({1'b0, y1}) - $signed({1'b0, y0});
    prod = $signed({{STEP_LOG2{diff[WIDTH]}}, diff}) * $signed({{(WIDTH + 1){1'b0}}, frac2});
    rnd  = prod + $signed(PW'(2 ** (STEP_LOG2 - 1)));
    // upper slice of rnd is the arithmetic right shift by STEP_LOG2
    sum  = {1'b0, y0} + rnd[PW-1:STEP_LOG2];
    res  = sum[WIDTH-1:0];
  end

  assign unused_bits = ^{off[WIDTH:ADDR_W+STEP_LOG2], rnd[STEP_LOG2-1:0], sum[WIDTH]};
`else
  exp_lut_rom #(
    .WIDTH(WIDTH), .FRAC(FRAC), .X_RANGE(X_RANGE), .STEP_LOG2(STEP_LOG2),
    .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) u_rom (
    .clk(clk), .en(adv),
    .addr_a(idx1), .data_a(y0)
  );

  assign res         = y0;
  assign unused_bits = ^{off[WIDTH:ADDR_W+STEP_LOG2], frac2};
`endif

  // S3 register; payload forced to zero whenever the slot is a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      exp_out   <= '0;
      out_tag   <= '0;
      out_clamp <= '0;
    end else if (adv) begin
      out_valid <= v2;
      exp_out   <= v2 ? res : '0;
      out_tag   <= v2 ? tag2 : '0;
      out_clamp <= v2 ? clamp2 : '0;
    end
  end

endmodule
